init_seq: RTL and testbench
===========================

INIT_SEQ -- requirements
Module: init_seq

Interface
REQ-001 Parameter N_CH, default 4: number of init-pulse channels, 1..16.
REQ-002 Parameter CNT_W, default 16: sequence counter width.
REQ-003 Parameter WAIT_LEN, default 200: terminal count of the sequence.
REQ-004 Parameter ST_VEC, default {16'd100,16'd100,16'd24,16'd4}: packed N_CH*CNT_W per-channel start counts; channel k uses slice k.
REQ-005 Parameter PW, default 1: pulse width in clk cycles, 1..255.
REQ-006 Parameter WORD_VEC, default {4{16'd2}}: packed N_CH*16 constant configuration words; channel k uses slice k.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 locked  input  1  PLL lock, asynchronous to clk.
REQ-010 restart  input  1  synchronous one-cycle request to re-run the sequence.
REQ-011 pulse  output  N_CH  per-channel init/latch strobes, registered.
REQ-012 word  output  N_CH*16  constant words; word slice k equals WORD_VEC slice k at all times, including during reset.
REQ-013 busy  output  1  high while the sequence is counting, registered.
REQ-014 done  output  1  high once the sequence completes, registered.
REQ-015 relock  output  1  one-cycle flag: lock was lost during COUNT or DONE.

Function
REQ-016 locked SHALL pass through a two-flop synchronizer (locked_s) before any use.
REQ-017 FSM states SHALL be IDLE, COUNT, DONE.
REQ-018 IDLE: cnt=0, busy=0, done=0; go to COUNT on the first clock with locked_s=1.
REQ-019 COUNT: busy=1; cnt increments by 1 per clock; on the clock where cnt==WAIT_LEN, go to DONE and cnt holds.
REQ-020 DONE: done=1, busy=0, cnt holds at WAIT_LEN.
REQ-021 restart=1 in DONE SHALL clear cnt to 0 and enter COUNT on the next clock; done drops the same clock busy rises.
REQ-022 restart SHALL be ignored in IDLE and COUNT.
REQ-023 locked_s=0 in COUNT or DONE SHALL force IDLE next clock, clear cnt, busy, done and all pulse bits, and assert relock for exactly one cycle.
REQ-024 locked_s=0 takes priority over restart on the same clock.
REQ-025 pulse[k] SHALL go high on the clock after the cycle where cnt==ST_k in COUNT, and stay high for exactly PW cycles.
REQ-026 A pulse in progress SHALL be truncated only by the lock loss of REQ-023 or by reset; entering DONE SHALL NOT truncate it.
REQ-027 Channels with equal start counts SHALL pulse on the same cycles.
REQ-028 Elaboration SHALL fail unless every ST_k+PW <= WAIT_LEN and WAIT_LEN < 2^CNT_W.
REQ-029 cnt SHALL never wrap; it saturates at WAIT_LEN.
REQ-030 Latency: with locked stable high, 2 synchronizer cycles, then 1 IDLE cycle, then WAIT_LEN+1 COUNT cycles, with done high on the following cycle.

Reset
REQ-031 rst=0 SHALL asynchronously set state=IDLE, cnt=0, both synchronizer flops=0, and pulse, busy, done, relock=0.
REQ-032 Release of rst SHALL be the only action needed to start a sequence when locked is already high.
REQ-033 Reset asserted mid-pulse SHALL clear pulse immediately, with no residual cycles after release.

Verification (N_CH=4, WAIT_LEN=20, ST={18,5,5,2}, PW=2)
REQ-034 locked held high, rst released at cycle 0 -> pulse[0] high at cnt 3..4, pulse[1:2] high together at cnt 6..7, pulse[3] high at cnt 19..20; done rises after cnt=20; busy low after that.
REQ-035 locked dropped when cnt=6 -> relock high one cycle, pulse[1:2] cleared, done=0; relock -> full sequence re-run from cnt=0.
REQ-036 restart pulsed in DONE -> cnt 0, busy=1, done=0 next clock; all four pulses repeat at the same offsets.
REQ-037 restart pulsed at cnt=10 -> ignored; done rises at the same cycle as an unperturbed run.
REQ-038 rst asserted while pulse[3] is high -> all outputs 0 immediately; word equals WORD_VEC throughout.
REQ-039 restart and locked loss on the same clock in DONE -> IDLE, relock=1, no COUNT entry until locked_s returns high.

Source files
------------

// File: rtl/init_seq.sv
// rtl/init_seq.sv - lock-qualified power-up init sequencer with per-channel strobes
module init_seq #(
    parameter int                      N_CH     = 4,
    parameter int                      CNT_W    = 16,
    parameter int                      WAIT_LEN = 200,
    parameter logic [N_CH*CNT_W-1:0]   ST_VEC   = {16'd100, 16'd100, 16'd24, 16'd4},
    parameter int                      PW       = 1,
    parameter logic [N_CH*16-1:0]      WORD_VEC = {4{16'd2}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 locked,
    input  logic                 restart,
    output logic [N_CH-1:0]      pulse,
    output logic [N_CH*16-1:0]   word,
    output logic                 busy,
    output logic                 done,
    output logic                 relock
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT_LEN);
    localparam logic [7:0]       PW_M1  = 8'(PW - 1);

    // Parameter sanity: reject configurations where a strobe could outlive the
    // count window or the terminal count cannot be represented.
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("init_seq: N_CH must be 1..16");
    end
    if (PW < 1 || PW > 255) begin : g_bad_pw
        $error("init_seq: PW must be 1..255");
    end
    if (longint'(WAIT_LEN) >= (longint'(1) << CNT_W)) begin : g_bad_wait
        $error("init_seq: WAIT_LEN does not fit in CNT_W bits");
    end
    for (genvar g = 0; g < N_CH; g++) begin : g_st_chk
        if (longint'(ST_VEC[g*CNT_W +: CNT_W]) + longint'(PW) > longint'(WAIT_LEN)) begin : g_bad_st
            $error("init_seq: channel start count plus PW exceeds WAIT_LEN");
        end
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sync_q, sync_d;
    logic [N_CH-1:0]    pulse_q, pulse_d;
    logic [7:0]         rem_q [N_CH];
    logic [7:0]         rem_d [N_CH];
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               relock_q, relock_d;
    logic               locked_s;
    logic               lost;

    assign locked_s = sync_q[1];
    assign lost     = (state_q != S_IDLE) && !locked_s;

    // Words are pure constants, independent of reset and clock.
    assign word   = WORD_VEC;
    assign pulse  = pulse_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign relock = relock_q;

    // Two-flop synchronizer input for the asynchronous lock indication.
    always_comb begin
        sync_d = {sync_q[0], locked};
    end

    // Sequencer next state: lock loss beats restart, cnt saturates at WAIT_LEN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!locked_s) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    relock_d = 1'b1;
                end else if (cnt_q == WAIT_C) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!locked_s) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    relock_d = 1'b1;
                end else if (restart) begin
                    state_d = S_COUNT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == S_COUNT);
        done_d = (state_d == S_DONE);
    end

    // Per-channel strobes: fire after cnt hits the start count, hold PW cycles,
    // cut short only by lock loss (reset handled by the register block).
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            pulse_d[k] = pulse_q[k];
            rem_d[k]   = rem_q[k];
            if (lost) begin
                pulse_d[k] = 1'b0;
                rem_d[k]   = '0;
            end else if (state_q == S_COUNT && cnt_q == ST_VEC[k*CNT_W +: CNT_W]) begin
                pulse_d[k] = 1'b1;
                rem_d[k]   = PW_M1;
            end else if (rem_q[k] != 8'd0) begin
                rem_d[k] = rem_q[k] - 8'd1;
            end else begin
                pulse_d[k] = 1'b0;
            end
        end
    end

    // State, counter, synchronizer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sync_q   <= '0;
            pulse_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            relock_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                rem_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync_q   <= sync_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            relock_q <= relock_d;
            for (int k = 0; k < N_CH; k++) begin
                rem_q[k] <= rem_d[k];
            end
        end
    end

endmodule

// File: tb/tb_init_seq.sv
// tb/tb_init_seq.sv - directed self-checking bench for init_seq
module tb_init_seq;

    localparam int          N_CH     = 4;
    localparam int          CNT_W    = 16;
    localparam int          WAIT_LEN = 20;
    localparam int          PW       = 2;
    localparam logic [63:0] ST_VEC   = {16'd18, 16'd5, 16'd5, 16'd2};
    localparam logic [63:0] WORD_VEC = {16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};

    logic        clk = 1'b0;
    logic        rst;
    logic        locked;
    logic        restart;
    logic [3:0]  pulse;
    logic [63:0] word;
    logic        busy;
    logic        done;
    logic        relock;

    int n_checks = 0;
    int n_errors = 0;
    int st_tab [4] = '{2, 5, 5, 18};

    init_seq #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .WAIT_LEN (WAIT_LEN),
        .ST_VEC   (ST_VEC),
        .PW       (PW),
        .WORD_VEC (WORD_VEC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .locked  (locked),
        .restart (restart),
        .pulse   (pulse),
        .word    (word),
        .busy    (busy),
        .done    (done),
        .relock  (relock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_pulse(input int j);
        logic [3:0] e;
        for (int k = 0; k < 4; k++) begin
            e[k] = (j > st_tab[k]) && (j <= st_tab[k] + PW);
        end
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},  64'(busy),  64'(1'b0));
        chk({tag, "_done"},  64'(done),  64'(1'b0));
        chk({tag, "_pulse"}, 64'(pulse), 64'(4'b0000));
    endtask

    // Checks count cycles cnt=from..to; optionally pulses restart at one cnt.
    task automatic check_count(input int from, input int to, input int restart_at);
        for (int j = from; j <= to; j++) begin
            chk($sformatf("cnt%0d_pulse", j), 64'(pulse), 64'(exp_pulse(j)));
            chk($sformatf("cnt%0d_busy", j), 64'(busy), 64'(1'b1));
            chk($sformatf("cnt%0d_done", j), 64'(done), 64'(1'b0));
            chk($sformatf("cnt%0d_relock", j), 64'(relock), 64'(1'b0));
            if (j == restart_at) restart = 1'b1;
            step();
            restart = 1'b0;
        end
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"},   64'(done),   64'(1'b1));
        chk({tag, "_busy"},   64'(busy),   64'(1'b0));
        chk({tag, "_pulse"},  64'(pulse),  64'(4'b0000));
        chk({tag, "_relock"}, 64'(relock), 64'(1'b0));
    endtask

    initial begin
        rst     = 1'b0;
        locked  = 1'b1;
        restart = 1'b0;
        #12;
        check_idle("reset");
        chk("reset_relock", 64'(relock), 64'(1'b0));
        chk("reset_word", word, WORD_VEC);

        // Release reset with lock already present: 2 sync + 1 idle cycle.
        @(negedge clk);
        rst = 1'b1;
        step();
        check_idle("sync1");
        step();
        check_idle("sync2");
        step();
        check_count(0, WAIT_LEN, -1);
        check_done("seq1");
        step();
        check_done("seq1_hold");

        // Restart from DONE re-runs the whole sequence.
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_count(0, WAIT_LEN, -1);
        check_done("seq2");

        // Restart during COUNT is ignored; done timing unchanged.
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_count(0, WAIT_LEN, 10);
        check_done("seq3");

        // Lock loss seen by the FSM while pulse[1:2] is in its first cycle.
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_count(0, 3, -1);
        chk("ll_cnt4_pulse", 64'(pulse), 64'(4'b0001));
        locked = 1'b0;
        step();
        chk("ll_cnt5_pulse", 64'(pulse), 64'(4'b0000));
        chk("ll_cnt5_busy", 64'(busy), 64'(1'b1));
        step();
        chk("ll_cnt6_pulse", 64'(pulse), 64'(4'b0110));
        step();
        check_idle("ll_idle");
        chk("ll_relock", 64'(relock), 64'(1'b1));
        locked = 1'b1;
        step();
        check_idle("ll_after1");
        chk("ll_relock_once", 64'(relock), 64'(1'b0));
        step();
        check_idle("ll_after2");
        step();
        check_count(0, WAIT_LEN, -1);
        check_done("seq4");

        // Restart and lock loss on the same clock in DONE: lock loss wins.
        locked = 1'b0;
        step();
        check_done("both_d1");
        step();
        check_done("both_d2");
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_idle("both_idle");
        chk("both_relock", 64'(relock), 64'(1'b1));
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle($sformatf("both_wait%0d", i));
            chk($sformatf("both_wait%0d_relock", i), 64'(relock), 64'(1'b0));
        end
        locked = 1'b1;
        step();
        check_idle("both_sync1");
        step();
        check_idle("both_sync2");
        step();
        check_count(0, 18, -1);

        // Reset while pulse[3] is high clears everything at once.
        chk("rst_pre_pulse", 64'(pulse), 64'(4'b1000));
        #2;
        rst = 1'b0;
        #1;
        check_idle("rst_mid");
        chk("rst_mid_relock", 64'(relock), 64'(1'b0));
        chk("rst_mid_word", word, WORD_VEC);
        @(negedge clk);
        check_idle("rst_hold");
        rst = 1'b1;
        step();
        check_idle("rst_rel1");
        step();
        check_idle("rst_rel2");
        step();
        check_count(0, WAIT_LEN, -1);
        check_done("seq5");
        chk("end_word", word, WORD_VEC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
